// File: rtl/data_unpacker.sv
// ---------------------------------------------------------------------------
// data_unpacker
//
// Purpose:
//   Inverse of the data packer on the trace read-out path. Each accepted
//   packed beat carries NS = N*PRECISION blocks of BLOCK_WIDTH bits. The beat
//   is re-expanded into NS/L output beats of L valid lanes, where L is picked
//   per chain by a firmware byte (0 -> N lanes, 1 -> M lanes, 2 -> 1 lane,
//   any other value -> the beat is consumed and dropped).
//
// Optional feature (compile-time macro):
//   UNPACK_SIGN_EXT_EN  defined   -> blocks are sign-extended to DATA_WIDTH
//                       undefined -> blocks are zero-extended
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   tracing      in   0 = configuration window open
//   configId     in   configuration target id
//   configData   in   configuration byte
//   valid_in     in   packed beat present
//   ready_in     out  unpacker accepts a beat this cycle
//   chainId_in   in   chain of the packed beat
//   vector_in    in   packed beat, N lanes of DATA_WIDTH
//   valid_out    out  output beat present (registered)
//   ready_out    in   consumer takes the beat this cycle
//   last_out     out  output beat is the last one of its input beat
//   vector_out   out  unpacked lanes, N lanes of DATA_WIDTH (registered)
// ---------------------------------------------------------------------------
module data_unpacker #(
    parameter int unsigned             N                  = 8,
    parameter int unsigned             M                  = 2,
    parameter int unsigned             DATA_WIDTH         = 32,
    parameter int unsigned             PRECISION          = 4,
    parameter int unsigned             MAX_CHAINS         = 4,
    parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
    // Chain c initial mode lives in bits [8*c +: 8].
    parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE   = '0,
    localparam int unsigned            CHAIN_W            = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tracing,
    input  logic [7:0]            configId,
    input  logic [7:0]            configData,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [CHAIN_W-1:0]    chainId_in,
    input  logic [DATA_WIDTH-1:0] vector_in [N],
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last_out,
    output logic [DATA_WIDTH-1:0] vector_out [N]
);

    localparam int unsigned BW     = DATA_WIDTH / PRECISION;
    localparam int unsigned NS     = N * PRECISION;
    localparam int unsigned BEAT_W = $clog2(NS + 1);

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // Mode helpers
    // ------------------------------------------------------------------
    function automatic int unsigned lanes_of(input logic [1:0] mode);
        case (mode)
            2'd0:    return N;
            2'd1:    return M;
            default: return 1;
        endcase
    endfunction

    // Index of the final output beat for a mode (B-1).
    function automatic logic [BEAT_W-1:0] last_beat(input logic [1:0] mode);
        case (mode)
            2'd0:    return BEAT_W'(NS / N - 1);
            2'd1:    return BEAT_W'(NS / M - 1);
            default: return BEAT_W'(NS - 1);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [BW-1:0] blk);
`ifdef UNPACK_SIGN_EXT_EN
        return DATA_WIDTH'($signed(blk));
`else
        return DATA_WIDTH'(blk);
`endif
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state;
    logic [1:0]        mode_r;
    logic [BEAT_W-1:0] beat;
    logic [BW-1:0]     hold [NS];
    logic [7:0]        firmware [MAX_CHAINS];
    logic [7:0]        byte_counter;

    // ------------------------------------------------------------------
    // Input side decode
    // ------------------------------------------------------------------
    logic [BW-1:0]     in_blocks [NS];
    logic [7:0]        in_fw;
    logic              in_mode_ok;
    logic [1:0]        in_mode;
    logic              accept;

    // Block j: lane j/PRECISION, MSB-first inside the lane.
    always_comb begin
        for (int unsigned j = 0; j < NS; j++) begin
            in_blocks[j] = vector_in[j / PRECISION][DATA_WIDTH - 1 - BW * (j % PRECISION) -: BW];
        end
    end

    always_comb begin
        in_fw = 8'hFF;
        if (32'(chainId_in) < MAX_CHAINS) begin
            in_fw = firmware[chainId_in];
        end
        in_mode_ok = (in_fw < 8'd3);
        in_mode    = in_fw[1:0];
    end

    // The final beat's handshake frees the hold register in the same cycle,
    // so the next packed beat is taken without a bubble.
    assign ready_in = (state == EMPTY) || ((state == DRAIN) && last_out && ready_out);
    assign accept   = valid_in && ready_in;

    // ------------------------------------------------------------------
    // Next output beat: built from the incoming beat on accept (beat 0),
    // otherwise from the hold register at beat+1.
    // ------------------------------------------------------------------
    logic [1:0]            src_mode;
    logic [BEAT_W-1:0]     src_beat;
    logic [BW-1:0]         src_blocks [NS];
    int unsigned           src_lanes;
    logic [DATA_WIDTH-1:0] next_vec [N];

    always_comb begin
        src_mode  = accept ? in_mode : mode_r;
        src_beat  = accept ? '0 : beat + 1'b1;
        src_lanes = lanes_of(src_mode);
        for (int unsigned j = 0; j < NS; j++) begin
            src_blocks[j] = accept ? in_blocks[j] : hold[j];
        end
        for (int unsigned k = 0; k < N; k++) begin
            next_vec[k] = '0;
            if ((k < src_lanes) && ((32'(src_beat) * src_lanes + k) < NS)) begin
                next_vec[k] = extend(src_blocks[32'(src_beat) * src_lanes + k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Data path / FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            mode_r    <= '0;
            beat      <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                vector_out[k] <= '0;
            end
            for (int unsigned j = 0; j < NS; j++) begin
                hold[j] <= '0;
            end
        end else if (accept) begin
            if (in_mode_ok) begin
                state      <= DRAIN;
                mode_r     <= in_mode;
                beat       <= '0;
                hold       <= in_blocks;
                vector_out <= next_vec;
                valid_out  <= 1'b1;
                last_out   <= (last_beat(in_mode) == '0);
            end else begin
                // Unsupported mode: the beat is consumed with no output.
                state     <= EMPTY;
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end else if ((state == DRAIN) && ready_out) begin
            if (last_out) begin
                state     <= EMPTY;
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end else begin
                beat       <= beat + 1'b1;
                vector_out <= next_vec;
                last_out   <= ((beat + 1'b1) == last_beat(mode_r));
            end
        end
    end

    // ------------------------------------------------------------------
    // Firmware configuration
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_counter <= '0;
            for (int unsigned c = 0; c < MAX_CHAINS; c++) begin
                firmware[c] <= INITIAL_FIRMWARE[8 * c +: 8];
            end
        end else if (configId != PERSONAL_CONFIG_ID) begin
            byte_counter <= '0;
        end else if (!tracing) begin
            for (int unsigned c = 0; c < MAX_CHAINS; c++) begin
                if (32'(byte_counter) == c) begin
                    firmware[c] <= configData;
                end
            end
            if (byte_counter != 8'hFF) begin
                byte_counter <= byte_counter + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_unpacker.sv
// ---------------------------------------------------------------------------
// tb_data_unpacker
//
// Directed bench for data_unpacker (N=8, M=2, DATA_WIDTH=32, PRECISION=4).
// Block j of a packed beat is given a known value by blk_val(); each output
// lane is compared against the block the unpacking rule selects.
// Honours UNPACK_SIGN_EXT_EN for the expected extension of blocks >= 0x80.
// ---------------------------------------------------------------------------
module tb_data_unpacker;

    logic        clk;
    logic        rst;
    logic        tracing;
    logic [7:0]  configId;
    logic [7:0]  configData;
    logic        valid_in;
    logic        ready_in;
    logic [1:0]  chainId_in;
    logic [31:0] vector_in [8];
    logic        valid_out;
    logic        ready_out;
    logic        last_out;
    logic [31:0] vector_out [8];

    int unsigned n_checks;
    int unsigned n_fail;

    data_unpacker #(
        .N                  (8),
        .M                  (2),
        .DATA_WIDTH         (32),
        .PRECISION          (4),
        .MAX_CHAINS         (4),
        .PERSONAL_CONFIG_ID (8'd0),
        .INITIAL_FIRMWARE   (32'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .chainId_in (chainId_in),
        .vector_in  (vector_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .last_out   (last_out),
        .vector_out (vector_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Block values per stimulus kind.
    function automatic logic [7:0] blk_val(input int unsigned kind, input int unsigned j);
        case (kind)
            0:       return 8'(32'h0A + (j % 4) + 16 * (j / 4));
            1:       return 8'(j);
            2:       return (j == 0) ? 8'hF0 : 8'(j);
            default: return 8'(32'h40 + j);
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [7:0] v);
`ifdef UNPACK_SIGN_EXT_EN
        return {{24{v[7]}}, v};
`else
        return {24'h0, v};
`endif
    endfunction

    task automatic make_vec(input int unsigned kind);
        for (int unsigned j = 0; j < 32; j++) begin
            vector_in[j / 4][31 - 8 * (j % 4) -: 8] = blk_val(kind, j);
        end
    endtask

    // Presents one packed beat at a falling edge; it is taken on the next rise.
    task automatic send(input int unsigned chain, input int unsigned kind);
        make_vec(kind);
        chainId_in = 2'(chain);
        valid_in   = 1'b1;
        #1 check("ready_in_accept", 32'(ready_in), 32'd1);
        @(negedge clk);
    endtask

    // Checks nbeats output beats of an input beat unpacked L lanes at a time.
    task automatic drain(input int unsigned lanes, input int unsigned kind, input bit stall,
                         input bit keep_valid, input int unsigned nbeats);
        int unsigned nb;
        int unsigned b;
        int unsigned guard;
        logic [31:0] exp;
        nb    = 32 / lanes;
        b     = 0;
        guard = 0;
        if (!keep_valid) valid_in = 1'b0;
        while (b < nbeats && guard < 400) begin
            check("valid_out", 32'(valid_out), 32'd1);
            check("last_out", 32'(last_out), 32'(b == nb - 1));
            for (int unsigned k = 0; k < 8; k++) begin
                exp = (k < lanes) ? ext(blk_val(kind, b * lanes + k)) : 32'h0;
                check($sformatf("lane%0d_beat%0d", k, b), vector_out[k], exp);
            end
            ready_out = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1 check("ready_in", 32'(ready_in), 32'(ready_out && (b == nb - 1)));
            if (ready_out) b++;
            guard++;
            @(negedge clk);
        end
        if (b < nbeats) check("drain_timeout", 32'(b), 32'(nbeats));
        ready_out = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        tracing    = 1'b1;
        configId   = 8'hFF;
        configData = 8'h00;
        valid_in   = 1'b0;
        chainId_in = 2'd0;
        ready_out  = 1'b1;
        for (int unsigned i = 0; i < 8; i++) vector_in[i] = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_last_out", 32'(last_out), 32'd0);
        check("rst_lane0", vector_out[0], 32'h0);
        check("rst_lane7", vector_out[7], 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready_in", 32'(ready_in), 32'd1);

        // Mode 0 from reset firmware: 4 full beats.
        send(0, 0);
        drain(8, 0, 1'b0, 1'b0, 4);
        check("idle_after_mode0", 32'(valid_out), 32'd0);

        // Firmware bytes 2,1,0,7 for chains 0..3.
        tracing  = 1'b0;
        configId = 8'd0;
        configData = 8'd2; @(negedge clk);
        configData = 8'd1; @(negedge clk);
        configData = 8'd0; @(negedge clk);
        configData = 8'd7; @(negedge clk);
        configId = 8'd1;
        tracing  = 1'b1;
        @(negedge clk);

        // Chain 1 -> mode 1: 16 beats of 2 lanes.
        send(1, 1);
        drain(2, 1, 1'b0, 1'b0, 16);

        // Back-to-back: chain 0 (mode 2) then chain 2 (mode 0), no idle cycle.
        send(0, 1);
        make_vec(3);
        chainId_in = 2'd2;
        drain(1, 1, 1'b0, 1'b1, 32);
        drain(8, 3, 1'b0, 1'b0, 4);
        check("idle_after_b2b", 32'(valid_out), 32'd0);

        // Mode 1 with random backpressure.
        send(1, 3);
        drain(2, 3, 1'b1, 1'b0, 16);

        // Chain 3 -> mode 7: beat consumed, no output.
        send(3, 1);
        valid_in = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            check("discard_valid_out", 32'(valid_out), 32'd0);
            check("discard_ready_in", 32'(ready_in), 32'd1);
            @(negedge clk);
        end

        // Block 0xF0 in mode 2, then reset in the middle of draining.
        send(0, 2);
        drain(1, 2, 1'b0, 1'b0, 3);
        check("mid_drain_valid", 32'(valid_out), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid_out", 32'(valid_out), 32'd0);
        check("async_rst_last_out", 32'(last_out), 32'd0);
        check("async_rst_lane0", vector_out[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready_in", 32'(ready_in), 32'd1);
        check("post_rst_valid_out", 32'(valid_out), 32'd0);
        @(negedge clk);

        // Firmware reloaded to zero by reset: chain 1 is back to mode 0.
        send(1, 0);
        drain(8, 0, 1'b0, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
